// File: rtl/decade_counter.sv
// decade_counter: BCD decade up-counter with enable and combinational terminal count
module decade_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  // >= rather than == so illegal states 10..15 also wrap to 0 on the next enabled edge
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (en) count <= (count >= WIDTH'(MAX_VAL)) ? '0 : count + 1'b1;
  assign tc = en && (count == WIDTH'(MAX_VAL));
endmodule

// File: tb/tb_decade_counter.sv
// tb_decade_counter: directed self-checking bench for decade_counter
module tb_decade_counter;
  logic clk = 0, rst = 1, en = 0;
  logic [3:0] count;
  logic tc;
  int total = 0, bad = 0;
  int m;

  decade_counter dut (.clk(clk), .rst(rst), .en(en), .count(count), .tc(tc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_model();
    m = (m == 9) ? 0 : m + 1;
  endtask

  initial begin
    rst = 1; en = 0;
    tick();
    chk("reset_count", count, 0);
    chk("reset_tc", tc, 0);
    rst = 0; en = 1; m = 0;
    chk("tc_at_0", tc, 0);
    for (int i = 0; i < 25; i++) begin
      chk("run_tc_pre", tc, (m == 9) ? 1 : 0);
      tick();
      step_model();
      chk("run_count", count, m);
    end
    chk("run_end", count, 5);
    for (int i = 0; i < 9; i++) begin
      tick();
      step_model();
    end
    chk("reach_4", count, 4);
    en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_4", count, 4);
      chk("hold_tc", tc, 0);
    end
    en = 1;
    tick();
    chk("resume_5", count, 5);
    tick();
    chk("resume_6", count, 6);
    tick(); tick(); tick();
    chk("at_9", count, 9);
    chk("tc_at_9", tc, 1);
    en = 0;
    #1 chk("tc_9_en0", tc, 0);
    en = 1;
    #1 chk("tc_9_en1", tc, 1);
    tick();
    chk("wrap_0", count, 0);
    chk("wrap_tc", tc, 0);
    for (int i = 0; i < 7; i++) tick();
    chk("at_7", count, 7);
    rst = 1;
    tick();
    chk("rst_mid", count, 0);
    rst = 0;
    tick();
    chk("post_rst_1", count, 1);
    tick();
    chk("post_rst_2", count, 2);
    en = 0;
    force dut.count = 4'd12;
    tick();
    release dut.count;
    #1;
    chk("illegal_hold", count, 12);
    chk("illegal_tc", tc, 0);
    en = 1;
    #1 chk("illegal_tc_en", tc, 0);
    tick();
    chk("illegal_wrap", count, 0);
    tick();
    chk("illegal_next", count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
